lsu_pipelined: RTL and testbench

- Parametrised load/store unit for the MEM stage of the RV32I/RV64I core.
- Replaces the fixed single-cycle data-memory access with a request/grant/response handshake to a variable-latency data memory.
- Adds misalignment detection, bus-timeout error reporting and 64-bit (RV64) access sizes.
- Sits between the EX/MEM pipeline register and the data memory; its ready output stalls the pipeline.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/lsu_pipelined_if.sv | 59 +++++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu_pipelined.sv | 153 +++++++++++++++
 tb/tb_lsu_pipelined.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared funct3 size encodings, FSM state type and size helpers
//           for the pipelined load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Byte-lane mask of an access before it is shifted into position
    function automatic logic [7:0] lsu_size_mask(input logic [2:0] funct3);
        logic [7:0] w_mask;
        case (funct3[1:0])
            2'b00:   w_mask = 8'h01;
            2'b01:   w_mask = 8'h03;
            2'b10:   w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
        return w_mask;
    endfunction

    // Offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] lsu_align_mask(input logic [2:0] funct3);
        logic [2:0] w_mask;
        case (funct3[1:0])
            2'b00:   w_mask = 3'b000;
            2'b01:   w_mask = 3'b001;
            2'b10:   w_mask = 3'b011;
            default: w_mask = 3'b111;
        endcase
        return w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pipe_if / lsu_mem_if
// Brief   : Pipeline-side request/response bus and data-memory bus of the
//           load/store unit. master drives requests, slave answers them.
// Revision: 1.0 - initial release
// ============================================================================
interface lsu_pipe_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [2:0]        req_funct3_i;
    logic [AWIDTH-1:0] req_addr_i;
    logic [DWIDTH-1:0] req_wdata_i;
    logic [4:0]        req_rd_i;
    logic              resp_valid_o;
    logic [DWIDTH-1:0] resp_data_o;
    logic [4:0]        resp_rd_o;
    logic              resp_misalign_o;
    logic              resp_buserr_o;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, resp_misalign_o, resp_buserr_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, resp_misalign_o, resp_buserr_o
    );
endinterface

interface lsu_mem_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic                mem_req_o;
    logic                mem_gnt_i;
    logic                mem_we_o;
    logic [AWIDTH-1:0]   mem_addr_o;
    logic [DWIDTH/8-1:0] mem_wstrb_o;
    logic [DWIDTH-1:0]   mem_wdata_o;
    logic                mem_rvalid_i;
    logic [DWIDTH-1:0]   mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Combinational lane logic: store strobe/data shift, legality and
//           alignment check, load data shift and sign/zero extension.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  wire  [2:0]                  i_st_funct3,
    input  wire                         i_st_we,
    input  wire  [$clog2(DWIDTH/8)-1:0] i_st_offset,
    input  wire  [DWIDTH-1:0]           i_st_wdata,
    output logic [DWIDTH/8-1:0]         o_wstrb,
    output logic [DWIDTH-1:0]           o_wdata,
    output logic                        o_misalign,
    input  wire  [2:0]                  i_ld_funct3,
    input  wire  [$clog2(DWIDTH/8)-1:0] i_ld_offset,
    input  wire  [DWIDTH-1:0]           i_rdata,
    output logic [DWIDTH-1:0]           o_ldata
);
    localparam int NB   = DWIDTH / 8;
    localparam int OFFW = $clog2(NB);

    logic [7:0]        w_size_mask;
    logic [2:0]        w_align_mask;
    logic              w_illegal;
    logic [DWIDTH-1:0] w_rshift;

    // Request side: illegal encodings fold into the misalign flag; lanes shift by the byte offset
    always_comb begin
        w_size_mask  = lsu_size_mask(i_st_funct3);
        w_align_mask = lsu_align_mask(i_st_funct3);
        w_illegal    = (i_st_funct3 == 3'b111)
                    || (i_st_we && i_st_funct3[2])
                    || ((DWIDTH == 32) && ((i_st_funct3 == LSU_D) || (i_st_funct3 == LSU_WU)));
        o_misalign   = w_illegal || ((i_st_offset & w_align_mask[OFFW-1:0]) != '0);
        o_wstrb      = w_size_mask[NB-1:0] << i_st_offset;
        o_wdata      = i_st_wdata << {i_st_offset, 3'b000};
    end

    // Response side: bring the addressed bytes to bit 0, then extend to full width
    always_comb begin
        w_rshift = i_rdata >> {i_ld_offset, 3'b000};
        case (i_ld_funct3)
            LSU_B:   o_ldata = DWIDTH'($signed(w_rshift[7:0]));
            LSU_BU:  o_ldata = DWIDTH'(w_rshift[7:0]);
            LSU_H:   o_ldata = DWIDTH'($signed(w_rshift[15:0]));
            LSU_HU:  o_ldata = DWIDTH'(w_rshift[15:0]);
            LSU_W:   o_ldata = DWIDTH'($signed(w_rshift[31:0]));
            LSU_WU:  o_ldata = DWIDTH'(w_rshift[31:0]);
            default: o_ldata = w_rshift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_pipelined.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pipelined
// Brief   : MEM-stage load/store unit with request/grant/response handshake to
//           a variable-latency data memory, misalign and bus-timeout reporting.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_pipelined
    import lsu_pkg::*;
#(
    parameter int AWIDTH         = 32,
    parameter int DWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input wire        clk,
    input wire        reset,
    lsu_pipe_if.slave pipe,
    lsu_mem_if.master mem
);
    localparam int NB   = DWIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
    // The counter starts at 0 on the first WAIT cycle, so this value marks the last one
    localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e      r_state;
    logic [2:0]      r_funct3;
    logic            r_we;
    logic [OFFW-1:0] r_offset;
    logic [4:0]      r_rd;
    logic [CW-1:0]   r_cnt;

    logic              w_accept;
    logic [OFFW-1:0]   w_offset;
    logic [AWIDTH-1:0] w_aligned_addr;
    logic [NB-1:0]     w_wstrb;
    logic [DWIDTH-1:0] w_wdata;
    logic [DWIDTH-1:0] w_ldata;
    logic              w_misalign;

    assign w_accept       = pipe.req_valid_i && pipe.req_ready_o;
    assign w_offset       = pipe.req_addr_i[OFFW-1:0];
    assign w_aligned_addr = {pipe.req_addr_i[AWIDTH-1:OFFW], {OFFW{1'b0}}};

    lsu_align #(
        .DWIDTH (DWIDTH)
    ) u_align (
        .i_st_funct3 (pipe.req_funct3_i),
        .i_st_we     (pipe.req_we_i),
        .i_st_offset (w_offset),
        .i_st_wdata  (pipe.req_wdata_i),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_misalign  (w_misalign),
        .i_ld_funct3 (r_funct3),
        .i_ld_offset (r_offset),
        .i_rdata     (mem.mem_rdata_i),
        .o_ldata     (w_ldata)
    );

    // Access FSM: capture, memory handshake, timeout and the one-cycle response pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state              <= IDLE;
            r_funct3             <= '0;
            r_we                 <= 1'b0;
            r_offset             <= '0;
            r_rd                 <= '0;
            r_cnt                <= '0;
            pipe.req_ready_o     <= 1'b1;
            pipe.resp_valid_o    <= 1'b0;
            pipe.resp_data_o     <= '0;
            pipe.resp_rd_o       <= '0;
            pipe.resp_misalign_o <= 1'b0;
            pipe.resp_buserr_o   <= 1'b0;
            mem.mem_req_o        <= 1'b0;
            mem.mem_we_o         <= 1'b0;
            mem.mem_addr_o       <= '0;
            mem.mem_wstrb_o      <= '0;
            mem.mem_wdata_o      <= '0;
        end else begin
            // Response fields are a pulse: only the cycle entering RESP sets them
            pipe.resp_valid_o    <= 1'b0;
            pipe.resp_data_o     <= '0;
            pipe.resp_rd_o       <= '0;
            pipe.resp_misalign_o <= 1'b0;
            pipe.resp_buserr_o   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3         <= pipe.req_funct3_i;
                        r_we             <= pipe.req_we_i;
                        r_offset         <= w_offset;
                        r_rd             <= pipe.req_rd_i;
                        pipe.req_ready_o <= 1'b0;
                        if (w_misalign) begin
                            r_state              <= RESP;
                            pipe.resp_valid_o    <= 1'b1;
                            pipe.resp_misalign_o <= 1'b1;
                            pipe.resp_rd_o       <= pipe.req_rd_i;
                        end else begin
                            r_state         <= REQ;
                            mem.mem_req_o   <= 1'b1;
                            mem.mem_we_o    <= pipe.req_we_i;
                            mem.mem_addr_o  <= w_aligned_addr;
                            mem.mem_wstrb_o <= pipe.req_we_i ? w_wstrb : '0;
                            mem.mem_wdata_o <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_gnt_i) begin
                        mem.mem_req_o <= 1'b0;
                        if (mem.mem_rvalid_i) begin
                            r_state           <= RESP;
                            pipe.resp_valid_o <= 1'b1;
                            pipe.resp_rd_o    <= r_rd;
                            pipe.resp_data_o  <= r_we ? '0 : w_ldata;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        r_state           <= RESP;
                        pipe.resp_valid_o <= 1'b1;
                        pipe.resp_rd_o    <= r_rd;
                        pipe.resp_data_o  <= r_we ? '0 : w_ldata;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        r_state            <= RESP;
                        pipe.resp_valid_o  <= 1'b1;
                        pipe.resp_rd_o     <= r_rd;
                        pipe.resp_buserr_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RESP: begin
                    r_state          <= IDLE;
                    pipe.req_ready_o <= 1'b1;
                end
                default: begin
                    r_state          <= IDLE;
                    pipe.req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_pipelined.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_pipelined
// Brief   : Self-checking bench for lsu_pipelined: a 32-bit and a 64-bit unit,
//           directed and randomized accesses against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_pipelined;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_reset, sel, t_valid, t_we, t_gnt, t_rvalid;
    logic [2:0]  t_f3;
    logic [31:0] t_addr;
    logic [63:0] t_wdata, t_rdata;
    logic [4:0]  t_rd;
    int          n_chk, n_pass;

    lsu_pipe_if #(.AWIDTH(32), .DWIDTH(32)) p32 ();
    lsu_mem_if  #(.AWIDTH(32), .DWIDTH(32)) m32 ();
    lsu_pipe_if #(.AWIDTH(32), .DWIDTH(64)) p64 ();
    lsu_mem_if  #(.AWIDTH(32), .DWIDTH(64)) m64 ();

    lsu_pipelined #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut32 (
        .clk(clk), .reset(t_reset), .pipe(p32), .mem(m32));
    lsu_pipelined #(.AWIDTH(32), .DWIDTH(64), .TIMEOUT_CYCLES(TO)) u_dut64 (
        .clk(clk), .reset(t_reset), .pipe(p64), .mem(m64));

    // Only the selected unit sees activity; the other idles
    assign p32.req_valid_i  = t_valid && !sel;
    assign p32.req_we_i     = t_we;
    assign p32.req_funct3_i = t_f3;
    assign p32.req_addr_i   = t_addr;
    assign p32.req_wdata_i  = t_wdata[31:0];
    assign p32.req_rd_i     = t_rd;
    assign m32.mem_gnt_i    = t_gnt && !sel;
    assign m32.mem_rvalid_i = t_rvalid && !sel;
    assign m32.mem_rdata_i  = t_rdata[31:0];
    assign p64.req_valid_i  = t_valid && sel;
    assign p64.req_we_i     = t_we;
    assign p64.req_funct3_i = t_f3;
    assign p64.req_addr_i   = t_addr;
    assign p64.req_wdata_i  = t_wdata;
    assign p64.req_rd_i     = t_rd;
    assign m64.mem_gnt_i    = t_gnt && sel;
    assign m64.mem_rvalid_i = t_rvalid && sel;
    assign m64.mem_rdata_i  = t_rdata;

    logic        w_ready, w_rv, w_mis, w_bus, w_mreq, w_mwe;
    logic [63:0] w_rdat, w_mwd;
    logic [4:0]  w_rrd;
    logic [31:0] w_maddr;
    logic [7:0]  w_mstrb;
    assign w_ready = sel ? p64.req_ready_o     : p32.req_ready_o;
    assign w_rv    = sel ? p64.resp_valid_o    : p32.resp_valid_o;
    assign w_rdat  = sel ? p64.resp_data_o     : {32'd0, p32.resp_data_o};
    assign w_rrd   = sel ? p64.resp_rd_o       : p32.resp_rd_o;
    assign w_mis   = sel ? p64.resp_misalign_o : p32.resp_misalign_o;
    assign w_bus   = sel ? p64.resp_buserr_o   : p32.resp_buserr_o;
    assign w_mreq  = sel ? m64.mem_req_o       : m32.mem_req_o;
    assign w_mwe   = sel ? m64.mem_we_o        : m32.mem_we_o;
    assign w_maddr = sel ? m64.mem_addr_o      : m32.mem_addr_o;
    assign w_mstrb = sel ? m64.mem_wstrb_o     : {4'd0, m32.mem_wstrb_o};
    assign w_mwd   = sel ? m64.mem_wdata_o     : {32'd0, m32.mem_wdata_o};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (dw=%0d t=%0t)", tag, act, exp, sel ? 64 : 32, $time);
    endtask

    // One access on unit s: gd = REQ cycles before grant, comb = rvalid with grant,
    // rdly = WAIT cycles before rvalid (>= TO means never)
    task automatic access(input bit s, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [4:0] rd, input int gd, input bit comb,
                          input int rdly, input logic [63:0] rdata);
        int dw, nb, off, bytes, exp_cyc, c;
        bit ill, mis, bus, seen;
        logic [63:0] dwm, e_data, e_strb, e_wd, sh, lm;
        sel   = s;
        dw    = s ? 64 : 32;
        nb    = dw / 8;
        dwm   = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        bytes = 1 << f3[1:0];
        ill   = (f3 == 3'b111) || (dw == 32 && (f3 == 3'b011 || f3 == 3'b110)) || (we && f3[2]);
        mis   = ill || ((addr % bytes) != 0);
        off   = int'(addr % nb);
        bus   = !mis && !comb && (rdly >= TO);
        e_strb = we ? ((((64'd1 << bytes) - 64'd1) << off) & ((64'd1 << nb) - 64'd1)) : 64'd0;
        e_wd   = (wd << (8 * off)) & dwm;
        sh     = (rdata & dwm) >> (8 * off);
        if (8 * bytes >= dw) e_data = sh;
        else begin
            lm     = (64'd1 << (8 * bytes)) - 64'd1;
            e_data = sh & lm;
            if (!f3[2] && sh[8 * bytes - 1]) e_data = e_data | ~lm;
            e_data = e_data & dwm;
        end
        if (we || mis || bus) e_data = 64'd0;
        if (mis)              exp_cyc = 1;
        else if (comb)        exp_cyc = 2 + gd;
        else if (rdly < TO)   exp_cyc = 3 + gd + rdly;
        else                  exp_cyc = 2 + gd + TO;

        @(posedge clk); #1;
        chk("ready_idle", w_ready, 1);
        t_valid = 1'b1; t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wd; t_rd = rd;
        @(posedge clk); #1;
        t_valid = 1'b0;
        c = 1; seen = 1'b0;
        while (!seen && c < 40) begin
            t_gnt = 1'b0; t_rvalid = 1'b0;
            if (w_rv) begin
                seen = 1'b1;
                chk("resp_cycle", 64'(c), 64'(exp_cyc));
                chk("resp_data", w_rdat, e_data);
                chk("resp_rd", w_rrd, rd);
                chk("resp_misalign", w_mis, mis);
                chk("resp_buserr", w_bus, bus);
                chk("resp_mem_req", w_mreq, 0);
                t_rvalid = 1'b1; t_rdata = ~rdata;
            end else begin
                chk("ready_busy", w_ready, 0);
                if (mis) chk("mis_no_req", w_mreq, 0);
                else if (c <= 1 + gd) begin
                    chk("mem_req", w_mreq, 1);
                    if (c == 1) begin
                        chk("mem_addr", w_maddr, addr & ~(32'(nb) - 32'd1));
                        chk("mem_we", w_mwe, we);
                        chk("mem_wstrb", w_mstrb, e_strb);
                        if (we) chk("mem_wdata", w_mwd, e_wd);
                    end
                    if (c == 1 + gd) begin
                        t_gnt = 1'b1;
                        if (comb) begin t_rvalid = 1'b1; t_rdata = rdata; end
                    end
                end else begin
                    chk("mem_req_wait", w_mreq, 0);
                    if (!comb && c == 2 + gd + rdly) begin t_rvalid = 1'b1; t_rdata = rdata; end
                end
            end
            @(posedge clk); #1;
            c++;
        end
        t_gnt = 1'b0;
        if (seen) begin
            chk("ready_after", w_ready, 1);
            chk("pulse_one", w_rv, 0);
            @(posedge clk); #1;
            t_rvalid = 1'b0;
            chk("stray_ignored", w_rv, 0);
        end else begin
            chk("resp_seen", 64'(seen), 1);
            t_rvalid = 1'b0; t_reset = 1'b1;
            @(posedge clk); #1;
            t_reset = 1'b0;
        end
    endtask

    // Reset while in WAIT: unit idles next cycle and ignores the late response
    task automatic reset_in_wait(input bit s);
        sel = s;
        @(posedge clk); #1;
        chk("rw_ready0", w_ready, 1);
        t_valid = 1'b1; t_we = 1'b0; t_f3 = LSU_W; t_addr = 32'h0000_0040; t_rd = 5'd7;
        @(posedge clk); #1;
        t_valid = 1'b0;
        chk("rw_req", w_mreq, 1);
        t_gnt = 1'b1;
        @(posedge clk); #1;
        t_gnt = 1'b0;
        chk("rw_wait_req", w_mreq, 0);
        t_reset = 1'b1;
        @(posedge clk); #1;
        t_reset = 1'b0;
        chk("rw_ready", w_ready, 1);
        chk("rw_mem_req", w_mreq, 0);
        chk("rw_resp0", w_rv, 0);
        t_rvalid = 1'b1; t_rdata = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        t_rvalid = 1'b0;
        chk("rw_resp1", w_rv, 0);
        chk("rw_ready1", w_ready, 1);
        @(posedge clk); #1;
        chk("rw_resp2", w_rv, 0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        n_chk = 0; n_pass = 0;
        sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_f3 = 3'd0; t_addr = 32'd0; t_wdata = 64'd0;
        t_rd = 5'd0; t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = 64'd0; t_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 t_reset = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(posedge clk); #1;
            chk("rst_ready", w_ready, 1);
            chk("rst_resp_valid", w_rv, 0);
            chk("rst_resp_data", w_rdat, 0);
            chk("rst_mem_req", w_mreq, 0);
            chk("rst_mem_we", w_mwe, 0);
            chk("rst_mem_wstrb", w_mstrb, 0);
            chk("rst_mem_addr", w_maddr, 0);
            chk("rst_mem_wdata", w_mwd, 0);
        end

        // 32-bit directed
        access(0, 0, LSU_W,  32'h0100_0004, 64'd0,  5'd5,  0, 0, 1,  64'hDEAD_BEEF);
        access(0, 1, LSU_B,  32'h0100_0003, 64'hA5, 5'd0,  1, 1, 0,  64'd0);
        access(0, 0, LSU_B,  32'h0100_0003, 64'd0,  5'd9,  0, 0, 0,  64'hA500_0000);
        access(0, 0, LSU_BU, 32'h0100_0003, 64'd0,  5'd10, 0, 1, 0,  64'hA500_0000);
        access(0, 0, LSU_H,  32'h0100_0001, 64'd0,  5'd11, 0, 0, 0,  64'd0);
        access(0, 0, LSU_D,  32'h0100_0000, 64'd0,  5'd12, 0, 0, 0,  64'd0);
        access(0, 0, LSU_W,  32'h0100_0008, 64'd0,  5'd13, 0, 0, 99, 64'h1111_2222);
        access(0, 0, LSU_HU, 32'h0100_0002, 64'd0,  5'd14, 0, 1, 0,  64'h8765_4321);
        access(0, 1, LSU_H,  32'h0100_0002, 64'hBEEF, 5'd15, 2, 0, 3, 64'd0);
        // 64-bit directed
        access(1, 0, LSU_WU, 32'h0000_0104, 64'd0,  5'd16, 0, 0, 0,  64'h8000_0001_1234_5678);
        access(1, 1, LSU_D,  32'h0000_0108, 64'h0123_4567_89AB_CDEF, 5'd17, 0, 1, 0, 64'd0);
        access(1, 0, LSU_W,  32'h0000_0104, 64'd0,  5'd18, 1, 0, 2,  64'h8000_0001_1234_5678);
        access(1, 1, LSU_WU, 32'h0000_0100, 64'd0,  5'd19, 0, 0, 0,  64'd0);
        reset_in_wait(0);
        reset_in_wait(1);

        // Randomized accesses on both widths
        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            access(i[0], 1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                   {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
